valid_ctrl: RTL

Controller directly upstream of the per-index cache valid table. It owns that table's single index/write port and arbitrates four clients onto it: the reset-time clear sweep, fence.i flush-all, line-fill set-valid, and single-line invalidate. It also serves core tag lookups, returning the valid bit one cycle after each accepted lookup.

---
 rtl/valid_ctrl_pkg.sv | 38 +++
 rtl/valid_ctrl_if.sv | 40 ++++
 rtl/valid_ctrl.sv | 125 ++++++++++++
 3 files changed

// File: rtl/valid_ctrl_pkg.sv
// valid_ctrl_pkg
// Shared definitions for the cache valid-table controller: index width and
// depth defaults, FSM state encodings and a small state-class helper.
// The state encodings live as macros so other cache blocks that decode the
// controller state can use the same values.
// Build option: CACHE_VALID_INIT_SWEEP_EN (consumed by valid_ctrl).

`ifndef CACHE_INDEX_AW
`define CACHE_INDEX_AW 8
`endif

`ifndef CACHE_DEPTH
`define CACHE_DEPTH 256
`endif

`ifndef VC_ST_INIT
`define VC_ST_INIT  2'd0
`define VC_ST_IDLE  2'd1
`define VC_ST_FLUSH 2'd2
`endif

package valid_ctrl_pkg;

    localparam int VC_INDEX_AW = `CACHE_INDEX_AW;
    localparam int VC_DEPTH    = `CACHE_DEPTH;

    typedef enum logic [1:0] {
        VC_INIT  = `VC_ST_INIT,
        VC_IDLE  = `VC_ST_IDLE,
        VC_FLUSH = `VC_ST_FLUSH
    } vc_state_e;

    // INIT and FLUSH both own the table port and clear one entry per cycle.
    function automatic logic vc_is_sweep(input vc_state_e st);
        return (st == VC_INIT) || (st == VC_FLUSH);
    endfunction

endpackage

// File: rtl/valid_ctrl_if.sv
// valid_ctrl_if
// Client-side bundle of the valid-table controller: flush handshake,
// fill / invalidate write requests and the tag-lookup request/response.
// Modports:
//   master - the cache core / refill side driving requests
//   slave  - valid_ctrl
// Parameter INDEX_AW: cache index width.

interface valid_ctrl_if
    import valid_ctrl_pkg::*;
#(
    parameter int INDEX_AW = VC_INDEX_AW
);

    logic                flush_req_i;
    logic                flush_done_o;
    logic                ready_o;
    logic                fill_en_i;
    logic [INDEX_AW-1:0] fill_index_i;
    logic                inv_en_i;
    logic [INDEX_AW-1:0] inv_index_i;
    logic                lkp_en_i;
    logic [INDEX_AW-1:0] lkp_index_i;
    logic                lkp_ready_o;
    logic                lkp_vld_o;
    logic                hit_valid_o;

    modport master (
        output flush_req_i, fill_en_i, fill_index_i, inv_en_i, inv_index_i,
               lkp_en_i, lkp_index_i,
        input  flush_done_o, ready_o, lkp_ready_o, lkp_vld_o, hit_valid_o
    );

    modport slave (
        input  flush_req_i, fill_en_i, fill_index_i, inv_en_i, inv_index_i,
               lkp_en_i, lkp_index_i,
        output flush_done_o, ready_o, lkp_ready_o, lkp_vld_o, hit_valid_o
    );

endinterface

// File: rtl/valid_ctrl.sv
// valid_ctrl
// Owns the single index/write port of the per-index cache valid table and
// arbitrates the reset clear sweep, flush-all, fill set-valid and
// single-line invalidate onto it. Serves tag lookups with the valid bit one
// cycle after acceptance (the table read is registered).
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   bus (slave)     flush handshake, fill/inv requests, lookup req/resp
//   vt_index_o      valid-table index
//   vt_wr_en_o      valid-table write enable
//   vt_wr_valid_o   valid-table write data
//   vt_rd_valid_i   valid-table registered read data
//
// Build option CACHE_VALID_INIT_SWEEP_EN: when defined, reset enters INIT and
// clears every entry; when undefined, the table is assumed preloaded and
// reset enters IDLE directly.
//
// state | meaning
// ------+------------------------------------------------------------
// INIT  | post-reset clear sweep, one entry per cycle, then IDLE
// IDLE  | serve fill > inv > lookup; flush_req_i starts FLUSH
// FLUSH | flush-all clear sweep; flush_done_o on the last write

module valid_ctrl
    import valid_ctrl_pkg::*;
#(
    parameter int INDEX_AW = VC_INDEX_AW,
    parameter int DEPTH    = VC_DEPTH
) (
    input  logic                clk,
    input  logic                rst_n,
    valid_ctrl_if.slave         bus,
    output logic [INDEX_AW-1:0] vt_index_o,
    output logic                vt_wr_en_o,
    output logic                vt_wr_valid_o,
    input  logic                vt_rd_valid_i
);

`ifdef CACHE_VALID_INIT_SWEEP_EN
    localparam vc_state_e RESET_STATE = VC_INIT;
`else
    localparam vc_state_e RESET_STATE = VC_IDLE;
`endif

    localparam logic [INDEX_AW-1:0] LAST_INDEX = INDEX_AW'(DEPTH - 1);

    vc_state_e           state;
    logic [INDEX_AW-1:0] cnt;
    logic                lkp_vld_q;

    logic sweeping;
    logic idle;
    logic cnt_last;
    logic fill_go;
    logic inv_go;
    logic lkp_go;

    assign sweeping = vc_is_sweep(state);
    assign idle     = (state == VC_IDLE);
    assign cnt_last = (cnt == LAST_INDEX);

    // Fixed priority in IDLE: fill, then invalidate, then lookup.
    assign fill_go = idle & bus.fill_en_i;
    assign inv_go  = idle & bus.inv_en_i & ~bus.fill_en_i;
    assign lkp_go  = idle & bus.lkp_en_i & ~bus.fill_en_i & ~bus.inv_en_i;

    // Write enable is qualified with rst_n so the table sees no write while
    // reset is held, even though INIT is the reset state.
    always_comb begin
        vt_wr_en_o    = 1'b0;
        vt_wr_valid_o = 1'b0;
        vt_index_o    = bus.lkp_index_i;
        if (sweeping) begin
            vt_wr_en_o = rst_n;
            vt_index_o = cnt;
        end else if (fill_go) begin
            vt_wr_en_o    = rst_n;
            vt_wr_valid_o = 1'b1;
            vt_index_o    = bus.fill_index_i;
        end else if (inv_go) begin
            vt_wr_en_o = rst_n;
            vt_index_o = bus.inv_index_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RESET_STATE;
            cnt       <= '0;
            lkp_vld_q <= 1'b0;
        end else begin
            lkp_vld_q <= lkp_go;
            case (state)
`ifdef CACHE_VALID_INIT_SWEEP_EN
                VC_INIT,
`endif
                VC_FLUSH: begin
                    cnt <= cnt_last ? '0 : cnt + INDEX_AW'(1);
                    if (cnt_last) begin
                        state <= VC_IDLE;
                    end
                end
                VC_IDLE: begin
                    // A fill/inv accepted this cycle still writes; the sweep
                    // that follows clears it again.
                    if (bus.flush_req_i) begin
                        state <= VC_FLUSH;
                    end
                end
                default: begin
                    state <= RESET_STATE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign bus.ready_o      = idle;
    assign bus.lkp_ready_o  = lkp_go;
    assign bus.lkp_vld_o    = lkp_vld_q;
    assign bus.hit_valid_o  = lkp_vld_q & vt_rd_valid_i;
    assign bus.flush_done_o = (state == VC_FLUSH) & cnt_last;

endmodule
